sensor_semaforo: RTL and testbench

SENSOR_SEMAFORO -- requirements
Module: sensor_semaforo

---
 rtl/sensor_semaforo.sv | 180 ++++++++++++++++++
 tb/tb_sensor_semaforo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_semaforo.sv
`default_nettype none
// ============================================================================
// Module   : sensor_semaforo
// Brief    : Debounced detector/emergency front-end for a two-street traffic
//            light controller. Optional lamp monitor: SENSOR_SEMAFORO_MONITOR_EN
// Revision : 1.0
// ============================================================================
module sensor_semaforo #(
  parameter int DEB_CYCLES  = 4,
  parameter int EMER_HOLD   = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       emer_btn,
  input  logic [1:0] verde,
  input  logic [1:0] amarillo,
  input  logic [1:0] rojo,
  output logic       TA,
  output logic       TB,
  output logic       E,
  output logic       fault
);

  localparam logic [7:0] c_deb_last  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] c_hold_last = 8'(EMER_HOLD - 1);
  localparam logic [9:0] c_tmo_last  = 10'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  logic [2:0] w_raw;
  logic [2:0] w_filt;

  assign w_raw = {emer_btn, det_b, det_a};

  // Channel 0 = det_a, 1 = det_b, 2 = emer_btn
  generate
    for (genvar g = 0; g < 3; g++) begin : g_deb
      logic       r_sync1;
      logic       r_sync2;
      logic       r_filt;
      logic [7:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_filt  <= 1'b0;
          r_cnt   <= 8'd0;
        end else begin
          r_sync1 <= w_raw[g];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_filt) begin
            r_cnt <= 8'd0;
          end else if (r_cnt == c_deb_last) begin
            r_filt <= ~r_filt;
            r_cnt  <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      assign w_filt[g] = r_filt;
    end
  endgenerate

  // The filter flops are the registered request outputs.
  assign TA = w_filt[0];
  assign TB = w_filt[1];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_nxt;
  logic [9:0] r_tmo_cnt;
  logic [9:0] w_tmo_nxt;
  logic       w_tmo_hit;
  logic       w_ack;
  logic       w_mon_fault;
  logic       r_fault;

  assign w_ack = (rojo == 2'b11);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_filt[2]) begin
          w_state_nxt = ST_REQ;
          w_tmo_nxt   = 10'd0;
        end
      end
      ST_REQ: begin
        // Acknowledge takes priority over a coincident timeout.
        if (w_ack) begin
          w_state_nxt = ST_SERVE;
          w_hold_nxt  = 8'd0;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_tmo_hit = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 10'd1;
        end
      end
      ST_SERVE: begin
        if (r_hold_cnt == c_hold_last) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      ST_CLEAR: begin
        if (!w_filt[2]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 8'd0;
      r_tmo_cnt  <= 10'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
    end
  end

  assign E = (r_state == ST_REQ) || (r_state == ST_SERVE);

`ifdef SENSOR_SEMAFORO_MONITOR_EN
  logic r_mon_arm;
  logic w_onehot_a;
  logic w_onehot_b;

  // Exactly-one-of-three: odd parity excluding the all-ones case.
  assign w_onehot_a = (verde[0] ^ amarillo[0] ^ rojo[0]) & ~(verde[0] & amarillo[0] & rojo[0]);
  assign w_onehot_b = (verde[1] ^ amarillo[1] ^ rojo[1]) & ~(verde[1] & amarillo[1] & rojo[1]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mon_arm <= 1'b0;
    end else begin
      r_mon_arm <= 1'b1;
    end
  end

  assign w_mon_fault = r_mon_arm & (~w_onehot_a | ~w_onehot_b | (verde == 2'b11));
`else
  logic w_unused_lamps;
  assign w_unused_lamps = ^{verde, amarillo};
  assign w_mon_fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_tmo_hit || w_mon_fault) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_sensor_semaforo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_semaforo
// Brief    : Directed + random bench for sensor_semaforo against a window/
//            counter based reference model (honours SENSOR_SEMAFORO_MONITOR_EN)
// Revision : 1.0
// ============================================================================
module tb_sensor_semaforo;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 64;
`ifdef SENSOR_SEMAFORO_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, det_a, det_b, emer_btn;
  logic [1:0] verde, amarillo, rojo;
  logic       TA, TB, E, fault;

  int checks = 0;
  int errors = 0;

  sensor_semaforo #(.DEB_CYCLES(DEB), .EMER_HOLD(HOLD), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .det_a(det_a), .det_b(det_b), .emer_btn(emer_btn),
    .verde(verde), .amarillo(amarillo), .rojo(rojo),
    .TA(TA), .TB(TB), .E(E), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample history per channel, emergency phase counters.
  logic [15:0] m_hist [3];
  logic [2:0]  m_filt;
  int          m_phase;   // 0 idle, 1 waiting ack, 2 serving, 3 waiting release
  int          m_waited, m_served;
  logic        m_fault, m_armed;

  task automatic model_edge();
    logic [2:0] raw;
    logic       bad, all_diff;
    raw = {emer_btn, det_b, det_a};
    if (!reset) begin
      for (int c = 0; c < 3; c++) m_hist[c] = '0;
      m_filt = '0; m_phase = 0; m_waited = 0; m_served = 0;
      m_fault = 1'b0; m_armed = 1'b0;
    end else begin
      case (m_phase)
        0: if (m_filt[2]) begin m_phase = 1; m_waited = 0; end
        1: if (rojo == 2'b11) begin
             m_phase = 2; m_served = 0;
           end else begin
             m_waited++;
             if (m_waited >= TMO) m_fault = 1'b1;
           end
        2: begin m_served++; if (m_served == HOLD) m_phase = 3; end
        default: if (!m_filt[2]) m_phase = 0;
      endcase
      bad = ($countones({verde[0], amarillo[0], rojo[0]}) != 1) ||
            ($countones({verde[1], amarillo[1], rojo[1]}) != 1) || (verde == 2'b11);
      if (MON && m_armed && bad) m_fault = 1'b1;
      m_armed = 1'b1;
      // Filtered value flips once the last DEB synchronized samples (raw
      // two edges back) all disagree with it.
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++) if (m_hist[c][k] == m_filt[c]) all_diff = 1'b0;
        if (all_diff) m_filt[c] = ~m_filt[c];
        m_hist[c] = {m_hist[c][14:0], raw[c]};
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ta_model", TA, m_filt[0]);
    chk("tb_model", TB, m_filt[1]);
    chk("e_model", E, (m_phase == 1) || (m_phase == 2));
    chk("fault_model", fault, m_fault);
  endtask

  task automatic lamps(input logic [1:0] v, input logic [1:0] a, input logic [1:0] r);
    verde = v; amarillo = a; rojo = r;
  endtask

  task automatic do_reset();
    reset = 1'b0; det_a = 1'b0; det_b = 1'b0; emer_btn = 1'b0;
    step();
    step();
    chk("rst_ta", TA, 1'b0);
    chk("rst_e", E, 1'b0);
    chk("rst_fault", fault, 1'b0);
  endtask

  initial begin
    int first, highs;
    reset = 1'b0; det_a = 1'b0; det_b = 1'b0; emer_btn = 1'b0;
    lamps(2'b01, 2'b00, 2'b10);
    do_reset();

    // det_a rise visible on the 6th edge; TB untouched
    reset = 1'b1; det_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("ta_latency", TA, i == 6);
      chk("tb_quiet", TB, 1'b0);
    end

    // short det_b pulse rejected, long pulse passed with same width
    det_b = 1'b1;
    step(); step(); step();
    det_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("tb_short", TB, 1'b0);
    end
    det_b = 1'b1; first = 0; highs = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 9) det_b = 1'b0;
      step();
      if (TB) begin
        highs++;
        if (first == 0) first = i;
      end
    end
    chk("tb_long_first", first == 6, 1'b1);
    chk("tb_long_width", highs == 8, 1'b1);

    // emergency with acknowledge at cycle 20, no retrigger while held
    do_reset();
    lamps(2'b01, 2'b00, 2'b10);
    reset = 1'b1; emer_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 20) lamps(2'b00, 2'b00, 2'b11);
      step();
      chk("e_seq", E, (i >= 7) && (i <= 27));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk("e_no_retrig", E, 1'b0);
    end
    emer_btn = 1'b0;
    for (int i = 0; i < 10; i++) step();
    emer_btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("e_repress", E, i == 7);
    end

    // acknowledge timeout sets sticky fault, E held until ack
    do_reset();
    lamps(2'b10, 2'b00, 2'b01);
    reset = 1'b1; emer_btn = 1'b1;
    for (int i = 1; i <= 71; i++) begin
      step();
      chk("tmo_fault", fault, i >= 71);
      chk("tmo_e", E, i >= 7);
    end
    lamps(2'b00, 2'b00, 2'b11);
    step();
    chk("tmo_serve_fault", fault, 1'b1);
    chk("tmo_serve_e", E, 1'b1);

    // reset in SERVE with a pending det_a debounce
    det_a = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rst_serve_e", E, 1'b0);
    chk("rst_serve_fault", fault, 1'b0);
    chk("rst_serve_ta", TA, 1'b0);
    chk("rst_serve_tb", TB, 1'b0);
    reset = 1'b1; det_a = 1'b0; emer_btn = 1'b0;
    lamps(2'b01, 2'b00, 2'b10);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_residual_ta", TA, 1'b0);
      chk("no_residual_e", E, 1'b0);
    end

    // both greens for one cycle
    do_reset();
    reset = 1'b1;
    step(); step(); step();
    lamps(2'b11, 2'b00, 2'b00);
    step();
    chk("mon_fault", fault, MON);
    lamps(2'b01, 2'b00, 2'b10);
    step(); step();
    chk("mon_sticky", fault, MON);

    // randomized traffic
    do_reset();
    reset = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) det_a = ~det_a;
      if ($urandom_range(0, 7) == 0) det_b = ~det_b;
      if ($urandom_range(0, 9) == 0) emer_btn = ~emer_btn;
      case ($urandom_range(0, 99))
        0:       lamps(2'($urandom), 2'($urandom), 2'($urandom));
        1, 2:    lamps(2'b00, 2'b00, 2'b11);
        default: if ($urandom_range(0, 1) == 0) lamps(2'b01, 2'b00, 2'b10);
                 else lamps(2'b10, 2'b00, 2'b01);
      endcase
      reset = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
